// File: rtl/vid_stream_tpg_if.sv
// 4-pixel-per-beat RGB888 video stream: tdata carries 4 pixels,
// tuser marks the first beat of a frame, tlast the last beat of a line.
interface vid_stream_tpg_if;
  logic [95:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tuser,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/vid_stream_tpg.sv
// Video test-pattern transmitter: produces complete frames of solid,
// colour-bar, ramp or coordinate patterns with line/frame blanking and
// full backpressure support. All stream outputs come straight from flops.
module vid_stream_tpg #(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int H_BLANK    = 16,
  parameter int V_BLANK    = 64
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_enable,
  input  logic [1:0]        I_pattern,
  input  logic [23:0]       I_solid_rgb,
  vid_stream_tpg_if.master  vid,
  output logic [15:0]       O_frame_cnt,
  output logic              O_busy
);

  localparam int BEATS     = IMG_WIDTH / 4;
  localparam int BAR_BEATS = IMG_WIDTH / 32;
  localparam int XW        = $clog2(BEATS);
  localparam int YW        = $clog2(IMG_HEIGHT);
  localparam int BCW       = (BAR_BEATS > 1) ? $clog2(BAR_BEATS) : 1;
  localparam int KMAX      = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int KW        = $clog2(KMAX + 1);

  typedef enum logic [1:0] {IDLE, LINE, HBLANK, VBLANK} state_t;

  state_t          state_reg, state_next;
  logic [XW-1:0]   x_b_reg, x_b_next;
  logic [YW-1:0]   y_reg, y_next;
  logic [KW-1:0]   blank_reg, blank_next;
  logic [2:0]      bar_reg, bar_next;
  logic [BCW-1:0]  bar_cnt_reg, bar_cnt_next;
  logic [1:0]      pattern_reg, pattern_next;
  logic [23:0]     solid_reg, solid_next;
  logic [15:0]     frame_cnt_reg, frame_cnt_next;
  logic [7:0]      fc_lat_reg, fc_lat_next;
  logic [95:0]     tdata_reg, tdata_next;
  logic            tvalid_reg, tvalid_next;
  logic            tuser_reg, tuser_next;
  logic            tlast_reg, tlast_next;
  logic            busy_reg, busy_next;
  logic            accept;
  logic [23:0]     pix [4];

  assign accept = tvalid_reg & vid.tready;

  function automatic logic [23:0] bar_color(input logic [2:0] b);
    logic [23:0] c;
    case (b)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  function automatic logic [23:0] pixel_value(
    input logic [1:0]  pat,
    input logic [23:0] solid,
    input logic [2:0]  bar,
    input logic [7:0]  x8,
    input logic [7:0]  y8,
    input logic [7:0]  fc8
  );
    logic [23:0] p;
    case (pat)
      2'd0:    p = solid;
      2'd1:    p = bar_color(bar);
      2'd2:    p = {x8, x8, x8};
      default: p = {x8, y8, fc8};
    endcase
    return p;
  endfunction

  // Frame/line sequencing, counters and pattern latching
  always_comb begin
    state_next     = state_reg;
    x_b_next       = x_b_reg;
    y_next         = y_reg;
    blank_next     = blank_reg;
    bar_next       = bar_reg;
    bar_cnt_next   = bar_cnt_reg;
    pattern_next   = pattern_reg;
    solid_next     = solid_reg;
    frame_cnt_next = frame_cnt_reg;
    fc_lat_next    = fc_lat_reg;

    case (state_reg)
      IDLE: begin
        if (I_enable) begin
          pattern_next = I_pattern;
          solid_next   = I_solid_rgb;
          fc_lat_next  = frame_cnt_reg[7:0];
          x_b_next     = '0;
          y_next       = '0;
          bar_next     = '0;
          bar_cnt_next = '0;
          state_next   = LINE;
        end
      end

      LINE: begin
        if (accept) begin
          if (int'(x_b_reg) == BEATS - 1) begin
            x_b_next     = '0;
            bar_next     = '0;
            bar_cnt_next = '0;
            blank_next   = '0;
            if (int'(y_reg) == IMG_HEIGHT - 1) begin
              frame_cnt_next = frame_cnt_reg + 16'd1;
              state_next     = VBLANK;
            end else begin
              y_next     = y_reg + YW'(1);
              state_next = (H_BLANK == 0) ? LINE : HBLANK;
            end
          end else begin
            x_b_next = x_b_reg + XW'(1);
            // Bars are whole beats wide, so a beat counter replaces a divider
            if (int'(bar_cnt_reg) == BAR_BEATS - 1) begin
              bar_cnt_next = '0;
              bar_next     = bar_reg + 3'd1;
            end else begin
              bar_cnt_next = bar_cnt_reg + BCW'(1);
            end
          end
        end
      end

      HBLANK: begin
        if (int'(blank_reg) == H_BLANK - 1) begin
          state_next = LINE;
        end else begin
          blank_next = blank_reg + KW'(1);
        end
      end

      default: begin
        if (int'(blank_reg) == V_BLANK - 1) begin
          blank_next = '0;
          if (I_enable) begin
            pattern_next = I_pattern;
            solid_next   = I_solid_rgb;
            fc_lat_next  = frame_cnt_reg[7:0];
            y_next       = '0;
            state_next   = LINE;
          end else begin
            state_next = IDLE;
          end
        end else begin
          blank_next = blank_reg + KW'(1);
        end
      end
    endcase
  end

  // Pixel values for the beat that will be presented next cycle
  for (genvar gi = 0; gi < 4; gi++) begin : g_pix
    logic [7:0] x8;
    assign x8      = 8'({x_b_next, 2'(gi)});
    assign pix[gi] = pixel_value(pattern_next, solid_next, bar_next, x8,
                                 8'(y_next), fc_lat_next);
  end

  // Next values of the registered stream outputs; unchanged while stalled
  always_comb begin
    tvalid_next = (state_next == LINE);
    tuser_next  = tvalid_next && (x_b_next == '0) && (y_next == '0);
    tlast_next  = tvalid_next && (int'(x_b_next) == BEATS - 1);
    tdata_next  = tvalid_next ? {pix[3], pix[2], pix[1], pix[0]} : '0;
    busy_next   = (state_next != IDLE);
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_reg     <= IDLE;
      x_b_reg       <= '0;
      y_reg         <= '0;
      blank_reg     <= '0;
      bar_reg       <= '0;
      bar_cnt_reg   <= '0;
      pattern_reg   <= '0;
      solid_reg     <= '0;
      frame_cnt_reg <= '0;
      fc_lat_reg    <= '0;
      tdata_reg     <= '0;
      tvalid_reg    <= 1'b0;
      tuser_reg     <= 1'b0;
      tlast_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_b_reg       <= x_b_next;
      y_reg         <= y_next;
      blank_reg     <= blank_next;
      bar_reg       <= bar_next;
      bar_cnt_reg   <= bar_cnt_next;
      pattern_reg   <= pattern_next;
      solid_reg     <= solid_next;
      frame_cnt_reg <= frame_cnt_next;
      fc_lat_reg    <= fc_lat_next;
      tdata_reg     <= tdata_next;
      tvalid_reg    <= tvalid_next;
      tuser_reg     <= tuser_next;
      tlast_reg     <= tlast_next;
      busy_reg      <= busy_next;
    end
  end

  assign vid.tdata   = tdata_reg;
  assign vid.tvalid  = tvalid_reg;
  assign vid.tuser   = tuser_reg;
  assign vid.tlast   = tlast_reg;
  assign O_frame_cnt = frame_cnt_reg;
  assign O_busy      = busy_reg;

endmodule
